redun_mont_collect: RTL



---
 rtl/redun_mont_collect_if.sv | 37 +++
 rtl/redun_mont_collect.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/redun_mont_collect_if.sv
// ============================================================================
//  Module   : redun_mont_collect_if
//  Purpose  : Core-side, control and result handshake signals of redun_mont_collect.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface redun_mont_collect_if #(
   parameter int NUM_WRDS = 4,
   parameter int WRD_BITS = 8,
   parameter int CNT_BITS = 64
);
   logic                                i_start;
   logic [CNT_BITS-1:0]                 i_iter;
   logic [NUM_WRDS*WRD_BITS-1:0]        i_mod;
   logic [NUM_WRDS*(WRD_BITS+1)-1:0]    i_mul;
   logic                                i_mul_val;
   logic                                o_core_rst;
   logic [NUM_WRDS*WRD_BITS-1:0]        o_dat;
   logic                                o_val;
   logic                                i_rdy;
   logic                                o_busy;
   logic [CNT_BITS-1:0]                 o_cnt;
   logic                                o_err;

   modport master (
      output i_start, i_iter, i_mod, i_mul, i_mul_val, i_rdy,
      input  o_core_rst, o_dat, o_val, o_busy, o_cnt, o_err
   );

   modport slave (
      input  i_start, i_iter, i_mod, i_mul, i_mul_val, i_rdy,
      output o_core_rst, o_dat, o_val, o_busy, o_cnt, o_err
   );
endinterface

`default_nettype wire

// File: rtl/redun_mont_collect.sv
// ============================================================================
//  Module   : redun_mont_collect
//  Purpose  : Counts squarer iterations, captures the final redundant result,
//             collapses it to binary and fully reduces it modulo P.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module redun_mont_collect #(
   parameter int NUM_WRDS = 4,
   parameter int WRD_BITS = 8,
   parameter int MAX_SUB  = 4,
   parameter int CNT_BITS = 64
) (
   input  wire logic            i_clk,
   input  wire logic            i_rst,
   redun_mont_collect_if.slave  bus
);
   localparam int c_RW    = WRD_BITS + 1;
   localparam int c_BW    = NUM_WRDS * WRD_BITS;
   localparam int c_IDX_W = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;
   localparam int c_SUB_W = (MAX_SUB > 0) ? $clog2(MAX_SUB + 1) : 1;
   localparam logic [c_IDX_W-1:0] c_LAST    = c_IDX_W'(NUM_WRDS - 1);
   localparam logic [c_SUB_W-1:0] c_SUB_MAX = c_SUB_W'(MAX_SUB);

   typedef enum logic [4:0] {
      S_IDLE     = 5'b00001,
      S_RUN      = 5'b00010,
      S_COLLAPSE = 5'b00100,
      S_REDUCE   = 5'b01000,
      S_OUT      = 5'b10000
   } state_t;

   state_t                       r_state;
   logic [CNT_BITS-1:0]          r_target;
   logic [CNT_BITS-1:0]          r_cnt;
   logic [c_BW-1:0]              r_mod;
   logic [NUM_WRDS*c_RW-1:0]     r_mul;
   logic [c_BW-1:0]              r_res;
   logic [1:0]                   r_carry;
   logic [c_IDX_W-1:0]           r_idx;
   logic [c_SUB_W-1:0]           r_nsub;
   logic [c_BW-1:0]              r_dat;
   logic                         r_val;
   logic                         r_core_rst;
   logic                         r_err;

   logic [CNT_BITS-1:0]          w_cnt_nxt;
   logic [WRD_BITS+1:0]          w_acc;
   logic [c_BW+1:0]              w_value;
   logic [c_BW+1:0]              w_mod_ext;

   assign w_cnt_nxt = r_cnt + CNT_BITS'(1);
   // r_mul shifts right one word per collapse cycle, so word i is always at the bottom
   assign w_acc     = {1'b0, r_mul[WRD_BITS:0]} + {{WRD_BITS{1'b0}}, r_carry};
   assign w_value   = {r_carry, r_res};
   assign w_mod_ext = {2'b00, r_mod};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_target   <= '0;
         r_cnt      <= '0;
         r_mod      <= '0;
         r_mul      <= '0;
         r_res      <= '0;
         r_carry    <= '0;
         r_idx      <= '0;
         r_nsub     <= '0;
         r_dat      <= '0;
         r_val      <= 1'b0;
         r_core_rst <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_core_rst <= 1'b0;
         r_err      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  if (bus.i_iter == '0) begin
                     r_err <= 1'b1;
                  end else begin
                     r_target <= bus.i_iter;
                     r_mod    <= bus.i_mod;
                     r_cnt    <= '0;
                     r_state  <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (bus.i_mul_val) begin
                  r_cnt <= w_cnt_nxt;
                  if (w_cnt_nxt == r_target) begin
                     r_mul      <= bus.i_mul;
                     r_core_rst <= 1'b1;
                     r_carry    <= 2'b00;
                     r_idx      <= '0;
                     r_state    <= S_COLLAPSE;
                  end
               end
            end
            S_COLLAPSE: begin
               // result words enter at the top and settle in place after NUM_WRDS shifts
               r_mul   <= r_mul >> c_RW;
               r_res   <= {w_acc[WRD_BITS-1:0], r_res[c_BW-1:WRD_BITS]};
               r_carry <= w_acc[WRD_BITS+1:WRD_BITS];
               r_idx   <= r_idx + c_IDX_W'(1);
               if (r_idx == c_LAST) begin
                  r_nsub  <= '0;
                  r_state <= S_REDUCE;
               end
            end
            S_REDUCE: begin
               if (w_value >= w_mod_ext) begin
                  if (r_nsub == c_SUB_MAX) begin
                     r_err   <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     {r_carry, r_res} <= w_value - w_mod_ext;
                     r_nsub           <= r_nsub + c_SUB_W'(1);
                  end
               end else begin
                  // value < P fits in c_BW bits, so the carry bits are zero here
                  r_dat   <= r_res;
                  r_val   <= 1'b1;
                  r_state <= S_OUT;
               end
            end
            S_OUT: begin
               if (bus.i_rdy) begin
                  r_val   <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_core_rst = r_core_rst;
   assign bus.o_dat      = r_dat;
   assign bus.o_val      = r_val;
   assign bus.o_busy     = (r_state != S_IDLE);
   assign bus.o_cnt      = r_cnt;
   assign bus.o_err      = r_err;

endmodule

`default_nettype wire
